// File: rtl/dmem_responder.sv
// Stalling data-memory responder: word RAM plus an LED / switch / access-counter I/O window.
// Define DMEM_ACCESS_COUNTER_EN to map the 32-bit access counter at MMIO_BASE+2.
//
// state  | meaning
// S_IDLE | waiting for mem_en_i; a request is latched on acceptance
// S_WAIT | wait states, down-counter runs to terminal count 0
// S_RESP | one cycle: access performed with the latched request, ready_o pulses
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FFF0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        mem_en_i,
  input  logic        mem_wen_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [15:0] sw_in_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [15:0] led_out_o
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_LD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] led_q, led_d;
`ifdef DMEM_ACCESS_COUNTER_EN
  logic [31:0] acc_cnt_q, acc_cnt_d;
`endif

  logic [31:0] ram_q [DEPTH];

  logic                  resp;
  logic                  in_ram;
  logic                  is_led;
  logic                  is_sw;
  logic                  is_cnt;
  logic                  unmapped;
  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic [31:0]           rd_val;

  assign resp    = (state_q == S_RESP);
  assign in_ram  = ((addr_q >> DEPTH_LOG2) == 32'd0);
  assign ram_idx = addr_q[DEPTH_LOG2-1:0];
  assign is_led  = (addr_q == MMIO_BASE);
  assign is_sw   = (addr_q == MMIO_BASE + 32'd1);
`ifdef DMEM_ACCESS_COUNTER_EN
  assign is_cnt  = (addr_q == MMIO_BASE + 32'd2);
`else
  assign is_cnt  = 1'b0;
`endif
  assign unmapped = !(in_ram || is_led || is_sw || is_cnt);

  // RAM is decoded first so a low MMIO_BASE can never shadow RAM words
  always_comb begin
    rd_val = 32'd0;
    if (in_ram) begin
      rd_val = ram_q[ram_idx];
    end else if (is_led) begin
      rd_val = {16'd0, led_q};
    end else if (is_sw) begin
      rd_val = {16'd0, sw_in_i};
`ifdef DMEM_ACCESS_COUNTER_EN
    end else if (is_cnt) begin
      rd_val = acc_cnt_q;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = wen_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    led_d   = led_q;
`ifdef DMEM_ACCESS_COUNTER_EN
    acc_cnt_d = acc_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (mem_en_i) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          wen_d   = mem_wen_i;
          cnt_d   = WAIT_LD;
          state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (!wen_q) begin
          rdata_d = rd_val;
        end
        if (unmapped) begin
          err_d = 1'b1;
        end
        if (wen_q && is_led) begin
          led_d = wdata_q[15:0];
        end
`ifdef DMEM_ACCESS_COUNTER_EN
        // a write to the counter replaces the count and is itself not counted
        acc_cnt_d = (wen_q && is_cnt) ? wdata_q : acc_cnt_q + 32'd1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wen_q   <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      led_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      led_q   <= led_d;
    end
  end

`ifdef DMEM_ACCESS_COUNTER_EN
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      acc_cnt_q <= 32'd0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
    end
  end
`endif

  // gated by reset so a write whose response edge meets reset is dropped
  assign ram_we = reset_i && resp && wen_q && in_ram;

  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      ram_q[ram_idx] <= wdata_q;
    end
  end

  assign ready_o   = resp;
  assign busy_o    = (state_q != S_IDLE);
  assign err_o     = err_q;
  assign led_out_o = led_q;
  assign rdata_o   = (resp && !wen_q) ? rd_val : rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed table, reset corner cases,
// zero-wait back-to-back instance and a randomized run against a transaction-level model.
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'hFFFF_FFF0;
  localparam int          WAITC = 2;
  localparam logic [31:0] DEPTH = 32'd1024;

  logic        clk;
  logic        reset;
  logic        mem_en, mem_wen;
  logic [31:0] addr, wdata;
  logic [15:0] sw_in;
  logic [31:0] rdata;
  logic        ready, busy, err;
  logic [15:0] led_out;

  logic        z_mem_en, z_mem_wen;
  logic [31:0] z_addr, z_wdata;
  logic [15:0] z_sw_in;
  logic [31:0] z_rdata;
  logic        z_ready, z_busy, z_err;
  logic [15:0] z_led_out;

  int nchk = 0;
  int nerr = 0;

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(WAITC), .MMIO_BASE(BASE)) dut (
    .clk_i(clk), .reset_i(reset), .mem_en_i(mem_en), .mem_wen_i(mem_wen),
    .addr_i(addr), .wdata_i(wdata), .sw_in_i(sw_in), .rdata_o(rdata),
    .ready_o(ready), .busy_o(busy), .err_o(err), .led_out_o(led_out)
  );

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0), .MMIO_BASE(BASE)) dut0 (
    .clk_i(clk), .reset_i(reset), .mem_en_i(z_mem_en), .mem_wen_i(z_mem_wen),
    .addr_i(z_addr), .wdata_i(z_wdata), .sw_in_i(z_sw_in), .rdata_o(z_rdata),
    .ready_o(z_ready), .busy_o(z_busy), .err_o(z_err), .led_out_o(z_led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // transaction-level reference model
  logic [31:0] m_ram [int unsigned];
  logic [15:0] m_led;
  logic        m_err;
  logic [31:0] m_cnt;
  logic [31:0] m_rdata;

  task automatic model_clear();
    m_led = 16'd0; m_err = 1'b0; m_cnt = 32'd0; m_rdata = 32'd0;
  endtask

  task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [15:0] s, output logic [31:0] rd);
    logic cnt_written;
    cnt_written = 1'b0;
    rd = 32'd0;
    if (a < DEPTH) begin
      if (w) m_ram[a] = d;
      else rd = m_ram[a];
    end else if (a == BASE) begin
      if (w) m_led = d[15:0];
      else rd = {16'd0, m_led};
    end else if (a == BASE + 32'd1) begin
      if (!w) rd = {16'd0, s};
`ifdef DMEM_ACCESS_COUNTER_EN
    end else if (a == BASE + 32'd2) begin
      if (w) begin
        m_cnt = d;
        cnt_written = 1'b1;
      end else rd = m_cnt;
`endif
    end else begin
      m_err = 1'b1;
    end
    if (!cnt_written) m_cnt = m_cnt + 32'd1;
    if (!w) m_rdata = rd;
  endtask

  // one handshake; entered and left just after a rising edge with the DUT idle
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [15:0] s, output logic [31:0] rd, output int lat);
    mem_en = 1'b1; mem_wen = w; addr = a; wdata = d; sw_in = s;
    rd = 32'd0; lat = 0;
    @(posedge clk); #1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ready) begin
        lat = i;
        rd = rdata;
        chk("busy_at_ready", {31'd0, busy}, 32'd1);
        break;
      end
      chk("busy_wait", {31'd0, busy}, 32'd1);
    end
    mem_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; mem_en = 1'b0; z_mem_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_clear();
  endtask

  task automatic zero_run(input logic w);
    int idx;
    idx = 0;
    z_mem_en = 1'b1; z_mem_wen = w; z_addr = 32'd0; z_wdata = 32'h1111_0000;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("z_ready_pattern", {31'd0, z_ready}, 32'(c % 2));
      if (z_ready) begin
        if (!w) chk("z_rdata", z_rdata, 32'h1111_0000 + 32'(idx));
        idx++;
        if (idx == 3) z_mem_en = 1'b0;
        else begin
          z_addr = 32'(idx);
          z_wdata = 32'h1111_0000 + 32'(idx);
        end
      end
    end
    z_mem_en = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [15:0] s;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] rd, last_rd, exp_rd;
    int lat, nready;
    logic w;
    logic [31:0] a, d;
    logic [15:0] s;
    int r;

    vecs[0] = '{1'b1, 32'd5,              32'hDEAD_BEEF, 16'h0000, 32'h0,          1'b0, 16'h0000};
    vecs[1] = '{1'b0, 32'd5,              32'h0,         16'h0000, 32'hDEAD_BEEF,  1'b0, 16'h0000};
    vecs[2] = '{1'b1, BASE,               32'h0001_A5A5, 16'h0000, 32'h0,          1'b0, 16'hA5A5};
    vecs[3] = '{1'b0, BASE + 32'd1,       32'h0,         16'h00F0, 32'h0000_00F0,  1'b0, 16'hA5A5};
    vecs[4] = '{1'b1, BASE + 32'd1,       32'h0000_1234, 16'h00F0, 32'h0,          1'b0, 16'hA5A5};
    vecs[5] = '{1'b0, BASE,               32'h0,         16'h0000, 32'h0000_A5A5,  1'b0, 16'hA5A5};
    vecs[6] = '{1'b1, 32'd7,              32'h0BAD_0007, 16'h0000, 32'h0,          1'b0, 16'hA5A5};
    vecs[7] = '{1'b0, 32'h0000_8000,      32'h0,         16'h0000, 32'h0,          1'b1, 16'hA5A5};
    vecs[8] = '{1'b0, 32'd5,              32'h0,         16'h0000, 32'hDEAD_BEEF,  1'b1, 16'hA5A5};

    mem_en = 1'b0; mem_wen = 1'b0; addr = 32'd0; wdata = 32'd0; sw_in = 16'd0;
    z_mem_en = 1'b0; z_mem_wen = 1'b0; z_addr = 32'd0; z_wdata = 32'd0; z_sw_in = 16'd0;
    reset = 1'b1;
    do_reset();

    chk("reset_rdata", rdata, 32'd0);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_busy",  {31'd0, busy}, 32'd0);
    chk("reset_err",   {31'd0, err}, 32'd0);
    chk("reset_led",   {16'd0, led_out}, 32'd0);

    last_rd = 32'd0;
    foreach (vecs[i]) begin
      xact(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, rd, lat);
      chk("latency", 32'(lat), 32'(WAITC + 1));
      if (!vecs[i].w) begin
        chk("rdata", rd, vecs[i].exp_rd);
        last_rd = vecs[i].exp_rd;
      end
      chk("rdata_hold", rdata, last_rd);
      chk("err", {31'd0, err}, {31'd0, vecs[i].exp_err});
      chk("led", {16'd0, led_out}, {16'd0, vecs[i].exp_led});
    end

    // reset during the wait states abandons the write
    mem_en = 1'b1; mem_wen = 1'b1; addr = 32'd7; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    mem_en = 1'b0;
    chk("midrst_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_clear();
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_led", {16'd0, led_out}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    nready = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ready) nready++;
    end
    @(posedge clk); #1;
    chk("midrst_no_ready", 32'(nready), 32'd0);
    xact(1'b0, 32'd7, 32'd0, 16'd0, rd, lat);
    chk("midrst_ram_old", rd, 32'h0BAD_0007);

    // reset coinciding with the response edge of a write
    mem_en = 1'b1; mem_wen = 1'b1; addr = 32'd7; wdata = 32'hCAFE_0007;
    nready = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ready) begin
        nready = 1;
        break;
      end
    end
    chk("resp_rst_saw_ready", 32'(nready), 32'd1);
    reset = 1'b0; mem_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_clear();
    chk("resp_rst_busy", {31'd0, busy}, 32'd0);
    xact(1'b0, 32'd7, 32'd0, 16'd0, rd, lat);
    chk("resp_rst_ram_old", rd, 32'h0BAD_0007);

    // access counter
    do_reset();
    xact(1'b1, 32'd1, 32'h0000_00A1, 16'd0, rd, lat);
    xact(1'b1, 32'd2, 32'h0000_00A2, 16'd0, rd, lat);
    xact(1'b0, 32'd1, 32'd0, 16'd0, rd, lat);
    chk("cnt_ram_rd", rd, 32'h0000_00A1);
    xact(1'b0, BASE + 32'd2, 32'd0, 16'd0, rd, lat);
`ifdef DMEM_ACCESS_COUNTER_EN
    chk("cnt_three", rd, 32'd3);
    chk("cnt_err", {31'd0, err}, 32'd0);
    xact(1'b1, BASE + 32'd2, 32'hFFFF_FFFF, 16'd0, rd, lat);
    xact(1'b0, 32'd2, 32'd0, 16'd0, rd, lat);
    xact(1'b0, BASE + 32'd2, 32'd0, 16'd0, rd, lat);
    chk("cnt_wrap", rd, 32'd0);
`else
    chk("cnt_unmapped_rd", rd, 32'd0);
    chk("cnt_unmapped_err", {31'd0, err}, 32'd1);
`endif

    // randomized run against the model
    do_reset();
    m_ram.delete();
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      model_step(1'b1, 32'(i), d, 16'd0, exp_rd);
      xact(1'b1, 32'(i), d, 16'd0, rd, lat);
    end
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 19);
      if (r < 16)       a = 32'(r);
      else if (r == 16) a = BASE;
      else if (r == 17) a = BASE + 32'd1;
      else if (r == 18) a = BASE + 32'd2;
      else              a = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h0000_0400 + $urandom_range(0, 1000);
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      s = 16'($urandom);
      model_step(w, a, d, s, exp_rd);
      xact(w, a, d, s, rd, lat);
      chk("rnd_latency", 32'(lat), 32'(WAITC + 1));
      if (!w) chk("rnd_rdata", rd, exp_rd);
      chk("rnd_rdata_hold", rdata, m_rdata);
      chk("rnd_err", {31'd0, err}, {31'd0, m_err});
      chk("rnd_led", {16'd0, led_out}, {16'd0, m_led});
    end

    // zero wait states with mem_en held high
    zero_run(1'b1);
    zero_run(1'b0);
    chk("z_err", {31'd0, z_err}, 32'd0);
    chk("z_busy_idle", {31'd0, z_busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder side of the CPU data-memory interface: accepts word-addressed read/write requests, services them after a programmable number of wait states, and signals completion with a one-cycle `ready` pulse.
- Contains a word RAM and a small memory-mapped I/O window: LED output register, switch input, optional access counter.
- Sits between the CPU data-port signals (address = ALU result, write data = rd register, enable, write-enable) and the board I/O.
- Lets the CPU be paired with a stalling memory instead of a fixed-latency one.

Parameters:
- DEPTH_LOG2, 10: RAM holds 2**DEPTH_LOG2 32-bit words.
- WAIT_CYCLES, 2: wait states between accept and response (0..15).
- MMIO_BASE, 32'hFFFF_FFF0: base word address of the I/O window.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-low (0 = reset, sampled on rising clk).
- mem_en  in  1  request valid.
- mem_wen  in  1  1 = write, 0 = read; sampled with mem_en.
- addr  in  32  word address.
- wdata  in  32  write data.
- sw_in  in  16  board switches.
- rdata  out  32  read data; valid when ready=1, held until the next response.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high from the accept cycle until the ready cycle, inclusive.
- err  out  1  sticky: an access hit an unmapped address.
- led_out  out  16  LED register.

Behaviour:
- Reset (reset=0 at a clk edge) sets:
  - FSM to IDLE.
  - rdata=0, ready=0, busy=0, err=0, led_out=0.
  - Wait counter=0; latched request discarded.
  - RAM contents unchanged.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On mem_en=1, latch addr, wdata and mem_wen, and set busy=1.
  - Go to WAIT if WAIT_CYCLES>0, else to RESP.
  - mem_en=0 keeps the FSM in IDLE.
- WAIT:
  - Counter counts 1..WAIT_CYCLES, then the FSM moves to RESP.
  - mem_en, addr and wdata are ignored; only the latched copies are used.
- RESP (exactly one cycle):
  - Perform the access using the latched request.
  - Assert ready=1; busy stays 1.
  - Next state is IDLE.
- Latency: a request accepted at edge T produces ready at cycle T+1+WAIT_CYCLES.
- Initiator rule: hold the request stable until ready and drop mem_en in the cycle after ready. If mem_en is still 1 in IDLE, a new access is accepted; this is legal back-to-back operation.
- Address decode (latched address, 32-bit unsigned compare):
  - addr < 2**DEPTH_LOG2 → RAM word addr[DEPTH_LOG2-1:0].
  - MMIO_BASE+0 → led_out. Write: led_out <= wdata[15:0]. Read: {16'd0, led_out}.
  - MMIO_BASE+1 → switches, read-only. Read: {16'd0, sw_in sampled in the RESP cycle}. Write: ignored, no error.
  - MMIO_BASE+2 → counter (see Optional Feature).
  - Anything else → unmapped. Read returns 0, write is dropped, err <= 1.
- Read response: rdata updates in the RESP cycle.
- Write response: rdata holds its previous value; RAM/register updates at the end of the RESP cycle.
- A read of an address in the RESP cycle immediately after a write to it returns the new data.
- err clears only on reset.
- Reset asserted during WAIT or RESP:
  - The access is abandoned and no ready pulse is issued.
  - A write whose RESP edge coincides with reset is not performed.

Optional Feature:
- DMEM_ACCESS_COUNTER_EN defined:
  - 32-bit counter increments at every RESP cycle (reads and writes, mapped or not); wraps 32'hFFFF_FFFF→0.
  - Read of MMIO_BASE+2 returns the count excluding the current access.
  - Write to MMIO_BASE+2 sets counter <= wdata; that access is not counted.
  - Reset clears the counter.
- Not defined: MMIO_BASE+2 is unmapped (read 0, err <= 1); no counter logic.

Test Plan:
- Latency: WAIT_CYCLES=2; after reset release, write addr=5, wdata=32'hDEADBEEF → ready exactly 3 cycles after accept, busy high for those 3 cycles. Then read addr=5 → rdata=32'hDEADBEEF with ready.
- Zero wait: WAIT_CYCLES=0; hold mem_en=1 continuously with reads of addr 0,1,2 → ready on every second cycle, rdata follows RAM contents.
- MMIO: write MMIO_BASE with 32'h0001_A5A5 → led_out=16'hA5A5. Then sw_in=16'h00F0 and read MMIO_BASE+1 → rdata=32'h0000_00F0. Write MMIO_BASE+1 → err stays 0.
- Unmapped: read addr=32'h0000_8000 (DEPTH_LOG2=10) → rdata=0, err=1 and remains 1. A following valid read leaves err=1.
- Reset mid-access: start write addr=7, 32'h12345678; assert reset=0 during WAIT → no ready, busy=0, led_out=0. Then read addr=7 → old value, not 32'h12345678.
- Counter (DMEM_ACCESS_COUNTER_EN): reset, 3 RAM accesses, read MMIO_BASE+2 → 3. Write 32'hFFFF_FFFF to MMIO_BASE+2, 1 access, read → 0 (wrap).
